// File: rtl/alu_share_if.sv
// Bus between the front-end requesters, the shared ALU and the result consumer.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface alu_share_if;
    logic        req0_valid, req0_ready, req0_cin;
    logic [1:0]  req0_screen;
    logic [2:0]  req0_opcode;
    logic [3:0]  req0_a, req0_b;

    logic        req1_valid, req1_ready, req1_cin;
    logic [1:0]  req1_screen;
    logic [2:0]  req1_opcode;
    logic [3:0]  req1_a, req1_b;

    logic [1:0]  alu_screen;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_a, alu_b;
    logic        alu_cin, alu_cout, alu_ovf, alu_err;
    logic [11:0] alu_bcd;

    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, rsp_err;
    logic [11:0] rsp_bcd;

    modport slave (
        input  req0_valid, req0_screen, req0_opcode, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_screen, req1_opcode, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output alu_screen, alu_opcode, alu_a, alu_b, alu_cin,
        input  alu_cout, alu_ovf, alu_bcd, alu_err,
        output rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_err, rsp_bcd,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_screen, req0_opcode, req0_a, req0_b, req0_cin,
        output req1_valid, req1_screen, req1_opcode, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  alu_screen, alu_opcode, alu_a, alu_b, alu_cin,
        output alu_cout, alu_ovf, alu_bcd, alu_err,
        input  rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_err, rsp_bcd,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters: accept,
// hold operands for SETTLE_CYCLES, capture the ALU flags, return them tagged with the id.
module alu_share_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    alu_share_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant, cur_id, gnt_id, any_vld, accept, settle_done;
    logic [3:0]  settle_cnt;
    logic [13:0] win_op;

    // On a tie the side that did not win last time gets the grant.
    always_comb begin
        any_vld = bus.req0_valid | bus.req1_valid;
        gnt_id  = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            gnt_id = ~last_grant;
        win_op = gnt_id ? {bus.req1_screen, bus.req1_opcode, bus.req1_a, bus.req1_b, bus.req1_cin}
                        : {bus.req0_screen, bus.req0_opcode, bus.req0_a, bus.req0_b, bus.req0_cin};
    end

    assign accept         = (state == IDLE) && any_vld && !rst;
    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept && gnt_id;
    assign settle_done    = (state == DRIVE) && (settle_cnt == 4'(SETTLE_CYCLES - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)        state_nx = DRIVE;
            DRIVE:   if (settle_done)   state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            settle_cnt <= '0;
            {bus.alu_screen, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin} <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_cout  <= 1'b0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_bcd   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cur_id     <= gnt_id;
                last_grant <= gnt_id;
                settle_cnt <= '0;
                {bus.alu_screen, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin} <= win_op;
            end
            if (state == DRIVE && !settle_done)
                settle_cnt <= settle_cnt + 4'd1;
            // ALU outputs are sampled only once the operands have settled.
            if (settle_done) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= cur_id;
                bus.rsp_cout  <= bus.alu_cout;
                bus.rsp_ovf   <= bus.alu_ovf;
                bus.rsp_err   <= bus.alu_err;
                bus.rsp_bcd   <= bus.alu_bcd;
            end
            if (state == RESP && bus.rsp_ready)
                bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: one instance with SETTLE_CYCLES=1, one with 3,
// each behind a stub ALU; stimulus pushes hand-computed results, a monitor pops and compares.
module tb_alu_share_arbiter;
    typedef struct packed {
        logic [1:0] screen;
        logic [2:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } req_t;

    typedef struct packed {
        logic        id;
        logic        cout;
        logic        ovf;
        logic        err;
        logic [11:0] bcd;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic [1:0] vld     [2];
    req_t       req     [2][2];
    logic       rsp_rdy [2];
    logic [1:0] rdy     [2];
    logic       obs_vld [2];
    rsp_t       obs_rsp [2];
    req_t       alu_word[2];

    rsp_t exp_q [2][$];
    req_t pend  [4][$];
    int   acc_q [2][$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   wait_n  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_if bus [2] ();

    alu_share_arbiter #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst[0]), .bus(bus[0]));
    alu_share_arbiter #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst(rst[1]), .bus(bus[1]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_env
        localparam int S = (k == 0) ? 1 : 3;
        bit prev = 1'b0;
        int acc_t;

        assign bus[k].req0_valid  = vld[k][0];
        assign bus[k].req0_screen = req[k][0].screen;
        assign bus[k].req0_opcode = req[k][0].opcode;
        assign bus[k].req0_a      = req[k][0].a;
        assign bus[k].req0_b      = req[k][0].b;
        assign bus[k].req0_cin    = req[k][0].cin;
        assign bus[k].req1_valid  = vld[k][1];
        assign bus[k].req1_screen = req[k][1].screen;
        assign bus[k].req1_opcode = req[k][1].opcode;
        assign bus[k].req1_a      = req[k][1].a;
        assign bus[k].req1_b      = req[k][1].b;
        assign bus[k].req1_cin    = req[k][1].cin;
        assign bus[k].rsp_ready   = rsp_rdy[k];

        // Stub ALU
        assign bus[k].alu_bcd  = {4'h0, bus[k].alu_a, bus[k].alu_b};
        assign bus[k].alu_cout = bus[k].alu_a[3] & bus[k].alu_b[3];
        assign bus[k].alu_ovf  = bus[k].alu_cin;
        assign bus[k].alu_err  = (bus[k].alu_opcode == 3'b111);

        assign rdy[k]      = {bus[k].req1_ready, bus[k].req0_ready};
        assign obs_vld[k]  = bus[k].rsp_valid;
        assign obs_rsp[k]  = {bus[k].rsp_id, bus[k].rsp_cout, bus[k].rsp_ovf, bus[k].rsp_err, bus[k].rsp_bcd};
        assign alu_word[k] = {bus[k].alu_screen, bus[k].alu_opcode, bus[k].alu_a, bus[k].alu_b, bus[k].alu_cin};

        always @(negedge clk) begin
            if (obs_vld[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("dut%0d_rsp_without_op", k), 32'(obs_vld[k]), 32'd0);
                end else begin
                    check($sformatf("dut%0d_rsp", k), 32'(obs_rsp[k]), 32'(exp_q[k][0]));
                    check($sformatf("dut%0d_no_grant_in_resp", k), 32'(rdy[k]), 32'd0);
                    if (!prev && acc_q[k].size() != 0) begin
                        acc_t = acc_q[k].pop_front();
                        check($sformatf("dut%0d_latency", k), 32'(cyc - acc_t), 32'(S + 1));
                    end
                    if (rsp_rdy[k]) void'(exp_q[k].pop_front());
                end
            end
            prev = obs_vld[k];
        end
    end

    function automatic req_t mkr(input logic [1:0] s, input logic [2:0] op,
                                 input logic [3:0] a, input logic [3:0] b, input logic cin);
        return {s, op, a, b, cin};
    endfunction

    function automatic rsp_t mke(input logic id, input logic cout, input logic ovf,
                                 input logic err, input logic [11:0] bcd);
        return {id, cout, ovf, err, bcd};
    endfunction

    task automatic do_reset(input int k);
        rst[k]     = 1'b1;
        vld[k]     = 2'b00;
        rsp_rdy[k] = 1'b1;
        pend[2*k].delete();
        pend[2*k+1].delete();
        exp_q[k].delete();
        acc_q[k].delete();
        @(posedge clk);
        @(negedge clk);
        check($sformatf("dut%0d_reset_rsp_valid", k), 32'(obs_vld[k]), 32'd0);
        check($sformatf("dut%0d_reset_rsp", k), 32'(obs_rsp[k]), 32'd0);
        check($sformatf("dut%0d_reset_alu", k), 32'(alu_word[k]), 32'd0);
        check($sformatf("dut%0d_reset_ready", k), 32'(rdy[k]), 32'd0);
        rst[k] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives pending ops as fast as the arbiter takes them; gap>0 demands an exact issue interval.
    task automatic run(input int k, input int gap, input int bound);
        int n = 0;
        int last = -1;
        logic [1:0] hs;
        while ((vld[k] != 2'b00 || pend[2*k].size() != 0 || pend[2*k+1].size() != 0
                || exp_q[k].size() != 0) && n < bound) begin
            for (int i = 0; i < 2; i++)
                if (!vld[k][i] && pend[2*k+i].size() != 0) begin
                    req[k][i] = pend[2*k+i].pop_front();
                    vld[k][i] = 1'b1;
                end
            @(negedge clk);
            hs = vld[k] & rdy[k];
            if (hs != 2'b00) begin
                if (last >= 0 && gap > 0)
                    check($sformatf("dut%0d_issue_gap", k), 32'(cyc - last), 32'(gap));
                last = cyc;
                acc_q[k].push_back(cyc);
            end
            @(posedge clk);
            #1;
            vld[k] = vld[k] & ~hs;
            n++;
        end
        if (n >= bound) check($sformatf("dut%0d_run_timeout", k), 32'(exp_q[k].size()), 32'd0);
    endtask

    task automatic accept_one(input int k, input int n, input req_t r);
        int t = 0;
        req[k][n] = r;
        vld[k][n] = 1'b1;
        @(negedge clk);
        while (!rdy[k][n] && t < 10) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("dut%0d_accept", k), 32'(rdy[k][n]), 32'd1);
        acc_q[k].push_back(cyc);
        @(posedge clk);
        #1;
        vld[k][n] = 1'b0;
    endtask

    initial begin
        req_t r;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            vld[k] = 2'b00;
            rsp_rdy[k] = 1'b1;
            for (int n = 0; n < 2; n++) req[k][n] = '0;
        end
        do_reset(0);
        do_reset(1);

        // Tie straight after reset goes to req0, then grants alternate.
        pend[0].push_back(mkr(2'd1, 3'b001, 4'h1, 4'h2, 1'b1));
        pend[0].push_back(mkr(2'd2, 3'b010, 4'hF, 4'hF, 1'b1));
        pend[1].push_back(mkr(2'd3, 3'b111, 4'h8, 4'h9, 1'b0));
        pend[1].push_back(mkr(2'd0, 3'b011, 4'h0, 4'h7, 1'b0));
        exp_q[0].push_back(mke(1'b0, 1'b0, 1'b1, 1'b0, 12'h012));
        exp_q[0].push_back(mke(1'b1, 1'b1, 1'b0, 1'b1, 12'h089));
        exp_q[0].push_back(mke(1'b0, 1'b1, 1'b1, 1'b0, 12'h0FF));
        exp_q[0].push_back(mke(1'b1, 1'b0, 1'b0, 1'b0, 12'h007));
        run(0, 3, 60);

        // Single op from reset.
        do_reset(0);
        pend[0].push_back(mkr(2'd0, 3'b000, 4'hA, 4'hC, 1'b0));
        exp_q[0].push_back(mke(1'b0, 1'b1, 1'b0, 1'b0, 12'h0AC));
        run(0, 0, 20);

        // Backpressure on the first of a tied pair; last winner was req0 so req1 goes first.
        rsp_rdy[0] = 1'b0;
        pend[0].push_back(mkr(2'd1, 3'b100, 4'h5, 4'h6, 1'b0));
        pend[1].push_back(mkr(2'd2, 3'b101, 4'h9, 4'h1, 1'b1));
        exp_q[0].push_back(mke(1'b1, 1'b0, 1'b1, 1'b0, 12'h091));
        exp_q[0].push_back(mke(1'b0, 1'b0, 1'b0, 1'b0, 12'h056));
        fork
            run(0, 8, 60);
            begin
                wait_n = 0;
                while (!obs_vld[0] && wait_n < 20) begin
                    @(negedge clk);
                    wait_n++;
                end
                repeat (5) @(posedge clk);
                #1 rsp_rdy[0] = 1'b1;
            end
        join

        // Operands changed after the handshake must not reach the ALU.
        r = mkr(2'd3, 3'b110, 4'h3, 4'h4, 1'b0);
        exp_q[0].push_back(mke(1'b0, 1'b0, 1'b0, 1'b0, 12'h034));
        accept_one(0, 0, r);
        req[0][0].a = 4'hF;
        req[0][0].b = 4'hE;
        @(negedge clk);
        check("dut0_alu_hold", 32'(alu_word[0]), 32'(r));
        run(0, 0, 20);

        // Reset during DRIVE drops the op; nothing may come out afterwards.
        accept_one(0, 1, mkr(2'd1, 3'b111, 4'h2, 4'h2, 1'b1));
        do_reset(0);
        repeat (6) @(posedge clk);
        #1;
        pend[0].push_back(mkr(2'd0, 3'b000, 4'h1, 4'h1, 1'b0));
        exp_q[0].push_back(mke(1'b0, 1'b0, 1'b0, 1'b0, 12'h011));
        run(0, 0, 20);

        // SETTLE_CYCLES=3 instance.
        pend[3].push_back(mkr(2'd2, 3'b111, 4'h3, 4'h5, 1'b0));
        exp_q[1].push_back(mke(1'b1, 1'b0, 1'b0, 1'b1, 12'h035));
        run(1, 0, 30);
        pend[2].push_back(mkr(2'd1, 3'b001, 4'h9, 4'h9, 1'b1));
        exp_q[1].push_back(mke(1'b0, 1'b1, 1'b1, 1'b0, 12'h099));
        run(1, 0, 30);
        pend[2].push_back(mkr(2'd0, 3'b011, 4'h8, 4'h8, 1'b0));
        pend[3].push_back(mkr(2'd3, 3'b000, 4'h4, 4'h6, 1'b1));
        exp_q[1].push_back(mke(1'b1, 1'b0, 1'b1, 1'b0, 12'h046));
        exp_q[1].push_back(mke(1'b0, 1'b1, 1'b0, 1'b0, 12'h088));
        run(1, 5, 40);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at t=%0t", $time);
        $fatal(1);
    end
endmodule
